// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter: up/down, load with range check, wrap carry.
// All state changes on the falling edge of clock.
module bcd_mod_counter #(
  parameter int MIN    = 0,
  parameter int MOD    = 24,
  parameter int TENS_W = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              up,
  input  logic              load,
  input  logic [TENS_W-1:0] load_tens,
  input  logic [3:0]        load_ones,
  output logic [TENS_W-1:0] tens,
  output logic [3:0]        ones,
  output logic              carry,
  output logic              load_err
);

  localparam int MAX = MIN + MOD - 1;

  if (MOD < 2 || MAX > 99 || (MAX / 10) >= (1 << TENS_W)) begin : g_bad_cfg
    $error("bcd_mod_counter: illegal MIN/MOD/TENS_W");
  end

  localparam logic [TENS_W-1:0] MIN_T = TENS_W'(MIN / 10);
  localparam logic [3:0]        MIN_O = 4'(MIN % 10);
  localparam logic [TENS_W-1:0] MAX_T = TENS_W'(MAX / 10);
  localparam logic [3:0]        MAX_O = 4'(MAX % 10);

  logic [TENS_W-1:0] tens_q, tens_d;
  logic [3:0]        ones_q, ones_d;
  logic              carry_q, carry_d;
  logic              err_q, err_d;

  int  v, l;
  logic in_range, ld_ok;

  always_comb begin
    v        = 10 * int'(tens_q) + int'(ones_q);
    l        = 10 * int'(load_tens) + int'(load_ones);
    in_range = (ones_q <= 4'd9) && (v >= MIN) && (v <= MAX);
    ld_ok    = (load_ones <= 4'd9) && (l >= MIN) && (l <= MAX);
    tens_d   = tens_q;
    ones_d   = ones_q;
    carry_d  = 1'b0;
    err_d    = 1'b0;
    if (load) begin
      if (ld_ok) begin
        tens_d = load_tens;
        ones_d = load_ones;
      end else begin
        err_d = 1'b1;
      end
    end else if (enable) begin
      // Corrupt state recovers silently to MIN.
      if (!in_range) begin
        tens_d = MIN_T;
        ones_d = MIN_O;
      end else if (up) begin
        if (v == MAX) begin
          tens_d  = MIN_T;
          ones_d  = MIN_O;
          carry_d = 1'b1;
        end else if (ones_q == 4'd9) begin
          tens_d = tens_q + TENS_W'(1);
          ones_d = 4'd0;
        end else begin
          ones_d = ones_q + 4'd1;
        end
      end else begin
        if (v == MIN) begin
          tens_d  = MAX_T;
          ones_d  = MAX_O;
          carry_d = 1'b1;
        end else if (ones_q == 4'd0) begin
          tens_d = tens_q - TENS_W'(1);
          ones_d = 4'd9;
        end else begin
          ones_d = ones_q - 4'd1;
        end
      end
    end
  end

  always_ff @(negedge clock) begin
    if (reset) begin
      tens_q  <= MIN_T;
      ones_q  <= MIN_O;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      carry_q <= carry_d;
      err_q   <= err_d;
    end
  end

  assign tens     = tens_q;
  assign ones     = ones_q;
  assign carry    = carry_q;
  assign load_err = err_q;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Scoreboard bench for bcd_mod_counter: three configurations
// (0-23, 1-12, 0-59), directed vectors with hand-computed results.
module tb_bcd_mod_counter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic [2:0] rst_v = '0, en_v = '0, up_v = '0, ld_v = '0;
  logic [1:0] lt0 = '0, lt1 = '0;
  logic [2:0] lt2 = '0;
  logic [3:0] lo0 = '0, lo1 = '0, lo2 = '0;

  logic [1:0] t0, t1;
  logic [2:0] t2;
  logic [3:0] o0, o1, o2;
  logic [2:0] c_v, e_v;

  bcd_mod_counter u0 (
    .clock(clock), .reset(rst_v[0]), .enable(en_v[0]), .up(up_v[0]),
    .load(ld_v[0]), .load_tens(lt0), .load_ones(lo0),
    .tens(t0), .ones(o0), .carry(c_v[0]), .load_err(e_v[0])
  );

  bcd_mod_counter #(.MIN(1), .MOD(12), .TENS_W(2)) u1 (
    .clock(clock), .reset(rst_v[1]), .enable(en_v[1]), .up(up_v[1]),
    .load(ld_v[1]), .load_tens(lt1), .load_ones(lo1),
    .tens(t1), .ones(o1), .carry(c_v[1]), .load_err(e_v[1])
  );

  bcd_mod_counter #(.MIN(0), .MOD(60), .TENS_W(3)) u2 (
    .clock(clock), .reset(rst_v[2]), .enable(en_v[2]), .up(up_v[2]),
    .load(ld_v[2]), .load_tens(lt2), .load_ones(lo2),
    .tens(t2), .ones(o2), .carry(c_v[2]), .load_err(e_v[2])
  );

  typedef struct {
    int    id;
    int    t;
    int    o;
    bit    c;
    bit    e;
    string name;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic step(input int id, input bit rst, input bit en,
                      input bit u, input bit ld, input int lt,
                      input int lo, input int et, input int eo,
                      input bit ec, input bit ee, input string name);
    exp_t x;
    @(posedge clock);
    #1;
    rst_v = '0; en_v = '0; up_v = '0; ld_v = '0;
    rst_v[id] = rst;
    en_v[id]  = en;
    up_v[id]  = u;
    ld_v[id]  = ld;
    case (id)
      0: begin lt0 = lt[1:0]; lo0 = lo[3:0]; end
      1: begin lt1 = lt[1:0]; lo1 = lo[3:0]; end
      default: begin lt2 = lt[2:0]; lo2 = lo[3:0]; end
    endcase
    x.id = id; x.t = et; x.o = eo; x.c = ec; x.e = ee; x.name = name;
    q.push_back(x);
  endtask

  always @(posedge clock) begin
    if (q.size() > 0) begin
      exp_t x;
      int at, ao;
      x = q.pop_front();
      case (x.id)
        0: begin at = int'(t0); ao = int'(o0); end
        1: begin at = int'(t1); ao = int'(o1); end
        default: begin at = int'(t2); ao = int'(o2); end
      endcase
      vectors++;
      if (at != x.t || ao != x.o || c_v[x.id] != x.c || e_v[x.id] != x.e) begin
        miscompares++;
        $display("FAIL %s dut%0d: got %0d/%0d c=%0b e=%0b, want %0d/%0d c=%0b e=%0b",
                 x.name, x.id, at, ao, c_v[x.id], e_v[x.id],
                 x.t, x.o, x.c, x.e);
      end
    end
  end

  initial begin
    // 1: default 0..23 up count
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rst0");
    for (int i = 1; i <= 24; i++) begin
      int v;
      v = i % 24;
      step(0, 0, 1, 1, 0, 0, 0, v / 10, v % 10, i == 24, 0, "up24");
    end
    // 2: 12-hour range
    step(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, "rst12");
    for (int i = 1; i <= 11; i++) begin
      int v;
      v = i + 1;
      step(1, 0, 1, 1, 0, 0, 0, v / 10, v % 10, 0, 0, "up12");
    end
    step(1, 0, 1, 1, 0, 0, 0, 0, 1, 1, 0, "wrap12up");
    step(1, 0, 1, 0, 0, 0, 0, 1, 2, 1, 0, "wrap12dn");
    // 3: digit carry / borrow
    step(0, 0, 0, 0, 1, 0, 9, 0, 9, 0, 0, "ld09");
    step(0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0, "up10");
    step(0, 0, 0, 0, 1, 2, 0, 2, 0, 0, 0, "ld20");
    step(0, 0, 1, 0, 0, 0, 0, 1, 9, 0, 0, "dn19");
    // 4: rejected loads
    step(0, 0, 0, 0, 1, 2, 5, 1, 9, 0, 1, "ld25bad");
    step(0, 0, 0, 0, 1, 1, 10, 1, 9, 0, 1, "ld1Abad");
    step(0, 0, 0, 0, 1, 1, 7, 1, 7, 0, 0, "ld17");
    step(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, "hold17");
    // 5: priority
    step(0, 1, 1, 1, 1, 1, 7, 0, 0, 0, 0, "rstprio");
    step(0, 0, 1, 1, 1, 0, 5, 0, 5, 0, 0, "ldprio");
    step(0, 0, 0, 0, 1, 1, 4, 1, 4, 0, 0, "ld14");
    step(0, 0, 1, 1, 0, 0, 0, 1, 5, 0, 0, "up15");
    step(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, "rstmid");
    step(0, 0, 1, 0, 0, 0, 0, 2, 3, 1, 0, "dnwrap23");
    step(0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, "upwrap00");
    // 6: 0..59 range
    step(2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rst60");
    step(2, 0, 0, 0, 1, 5, 9, 5, 9, 0, 0, "ld59");
    step(2, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, "wrap60");
    for (int i = 0; i < 5; i++)
      step(2, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, "idle60");
    step(2, 0, 0, 0, 1, 6, 0, 0, 0, 0, 1, "ld60bad");
    repeat (3) @(posedge clock);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
